// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter for the shared GPIO register bus.
// Issues one write-enable pulse per transaction and verifies read-back.
module gpio_bus_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int READBACK_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [NUM_REQ*5-1:0]  req_addr_i,
  input  logic [NUM_REQ*26-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [31:0]           gpio_bus_o,
  input  logic [31:0]           gpio_rb_i,
  output logic                  rsp_valid_o,
  output logic [2:0]            rsp_id_o,
  output logic [25:0]           rsp_data_o,
  output logic                  rsp_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [2:0]  rr_q;
  logic [2:0]  id_q;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [25:0] data_q;
  logic [3:0]  cnt_q;

  logic                  gnt_found;
  logic [2:0]            gnt_idx;
  logic [2:0]            rr_nxt;
  logic [3:0]            cand;
  logic [NUM_REQ-1:0]    vbits;
  logic [NUM_REQ-1:0]    wbits;
  logic [NUM_REQ*5-1:0]  abits;
  logic [NUM_REQ*26-1:0] dbits;
  logic                  we_sel;
  logic [4:0]            addr_sel;
  logic [25:0]           data_sel;
  logic                  rb_last;
  logic                  rb_err;
  logic                  unused_rb;

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  assign unused_rb = gpio_rb_i[31];
  assign rb_last   = (cnt_q == 4'd1);
  assign rb_err    = (gpio_rb_i[30:26] != addr_q) |
                     (we_q & (gpio_rb_i[25:0] != data_q));

  // First pending requester at or after the rr pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    vbits     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = 4'(rr_q) + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      vbits = req_valid_i >> cand;
      if (!gnt_found && vbits[0]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

  // Select the granted requester's fields and the next rr pointer.
  always_comb begin
    wbits    = req_we_i >> gnt_idx;
    abits    = req_addr_i >> (5 * gnt_idx);
    dbits    = req_data_i >> (26 * gnt_idx);
    we_sel   = wbits[0];
    addr_sel = abits[4:0];
    data_sel = dbits[25:0];
    if (gnt_idx == 3'(NUM_REQ - 1)) rr_nxt = '0;
    else                            rr_nxt = gnt_idx + 3'd1;
  end

  // Accept pulse, only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == IDLE && gnt_found)
      req_ready_o = ONE << gnt_idx;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (rb_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Transaction latch, bus drive, wait counter and response capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      id_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      gpio_bus_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_found) begin
            id_q       <= gnt_idx;
            we_q       <= we_sel;
            addr_q     <= addr_sel;
            data_q     <= data_sel;
            rr_q       <= rr_nxt;
            gpio_bus_o <= {we_sel, addr_sel, data_sel};
          end else begin
            gpio_bus_o[31] <= 1'b0;
          end
        end
        ISSUE: begin
          gpio_bus_o <= {1'b0, addr_q, data_q};
          cnt_q      <= 4'(READBACK_LATENCY);
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (rb_last) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= id_q;
            rsp_data_o  <= gpio_rb_i[25:0];
            rsp_err_o   <= rb_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter.
// Two builds: READBACK_LATENCY 2 and 1.
module tb_gpio_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   rb_mode;
  int   n_pass = 0;
  int   n_total = 0;

  logic [3:0]   v0, we0, rdy0;
  logic [19:0]  ad0;
  logic [103:0] dt0;
  logic [31:0]  bus0, rb0;
  logic         rv0, rerr0;
  logic [2:0]   rid0;
  logic [25:0]  rdat0;

  logic [3:0]   v1, we1, rdy1;
  logic [19:0]  ad1;
  logic [103:0] dt1;
  logic [31:0]  bus1, rb1;
  logic         rv1, rerr1;
  logic [2:0]   rid1;
  logic [25:0]  rdat1;

  gpio_bus_arbiter #(.NUM_REQ(4), .READBACK_LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v0), .req_we_i(we0),
    .req_addr_i(ad0), .req_data_i(dt0),
    .req_ready_o(rdy0), .gpio_bus_o(bus0),
    .gpio_rb_i(rb0), .rsp_valid_o(rv0),
    .rsp_id_o(rid0), .rsp_data_o(rdat0),
    .rsp_err_o(rerr0)
  );

  gpio_bus_arbiter #(.NUM_REQ(4), .READBACK_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v1), .req_we_i(we1),
    .req_addr_i(ad1), .req_data_i(dt1),
    .req_ready_o(rdy1), .gpio_bus_o(bus1),
    .gpio_rb_i(rb1), .rsp_valid_o(rv1),
    .rsp_id_o(rid1), .rsp_data_o(rdat1),
    .rsp_err_o(rerr1)
  );

  // Read-back model: echo, unpopulated prefix, or stale data.
  always_comb begin
    rb0 = {1'b0, bus0[30:0]};
    if (rb_mode == 1) rb0 = 32'h0;
    else if (rb_mode == 2) rb0 = {1'b0, bus0[30:26], 26'h0};
  end

  assign rb1 = {1'b0, bus1[30:0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp0(inout int n);
    while (!rv0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 4'hF; we0 = '0; ad0 = '0; dt0 = '0;
    v1 = 4'hF; we1 = '0; ad1 = '0; dt1 = '0;
    tick();
    tick();
    n_total++;
    if (rdy0 !== 4'b0) $display("FAIL rst_ready: got %b want 0000", rdy0);
    else n_pass++;
    n_total++;
    if (rdy1 !== 4'b0) $display("FAIL rst_ready1: got %b want 0000", rdy1);
    else n_pass++;
    n_total++;
    if (bus0 !== 32'h0) $display("FAIL rst_bus: got %h want 0", bus0);
    else n_pass++;
    n_total++;
    if (rv0 !== 1'b0) $display("FAIL rst_rv: got %b want 0", rv0);
    else n_pass++;
    n_total++;
    if (rid0 !== 3'd0) $display("FAIL rst_id: got %0d want 0", rid0);
    else n_pass++;
    n_total++;
    if (rdat0 !== 26'h0) $display("FAIL rst_data: got %h want 0", rdat0);
    else n_pass++;
    n_total++;
    if (rerr0 !== 1'b0) $display("FAIL rst_err: got %b want 0", rerr0);
    else n_pass++;
    v0 = '0;
    v1 = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int n;
    v0 = 4'b0010; we0 = 4'b0010;
    ad0[9:5] = 5'b01011; dt0[51:26] = 26'h2A5A5A5;
    #1;
    n_total++;
    if (rdy0 !== 4'b0010) $display("FAIL wr_ready: got %b want 0010", rdy0);
    else n_pass++;
    tick();
    v0 = '0;
    n_total++;
    if (bus0 !== 32'hAEA5A5A5) $display("FAIL wr_issue_bus: got %h want aea5a5a5", bus0);
    else n_pass++;
    tick();
    n_total++;
    if (bus0 !== 32'h2EA5A5A5) $display("FAIL wr_wait_bus: got %h want 2ea5a5a5", bus0);
    else n_pass++;
    n = 2;
    wait_rsp0(n);
    n_total++;
    if (n !== 4) $display("FAIL wr_latency: got %0d want 4", n);
    else n_pass++;
    n_total++;
    if (rdat0 !== 26'h2A5A5A5) $display("FAIL wr_data: got %h want 2a5a5a5", rdat0);
    else n_pass++;
    n_total++;
    if (rerr0 !== 1'b0) $display("FAIL wr_err: got %b want 0", rerr0);
    else n_pass++;
    n_total++;
    if (rid0 !== 3'd1) $display("FAIL wr_id: got %0d want 1", rid0);
    else n_pass++;
    tick();
    n_total++;
    if (rv0 !== 1'b0) $display("FAIL wr_strobe_len: got %b want 0", rv0);
    else n_pass++;
    n_total++;
    if (rdat0 !== 26'h2A5A5A5) $display("FAIL wr_hold: got %h want 2a5a5a5", rdat0);
    else n_pass++;
  endtask

  task automatic test_read_echo();
    int n;
    v0 = 4'b0100; we0 = 4'b0000;
    ad0[14:10] = 5'b10110; dt0[77:52] = 26'h0ABCDEF;
    #1;
    n_total++;
    if (rdy0 !== 4'b0100) $display("FAIL rd_ready: got %b want 0100", rdy0);
    else n_pass++;
    tick();
    v0 = '0;
    n_total++;
    if (bus0 !== 32'h58ABCDEF) $display("FAIL rd_bus: got %h want 58abcdef", bus0);
    else n_pass++;
    n = 1;
    wait_rsp0(n);
    n_total++;
    if (rerr0 !== 1'b0) $display("FAIL rd_err: got %b want 0", rerr0);
    else n_pass++;
    n_total++;
    if (rdat0 !== 26'h0ABCDEF) $display("FAIL rd_data: got %h want 0abcdef", rdat0);
    else n_pass++;
    tick();
  endtask

  task automatic test_read_unused();
    int n;
    logic saw31;
    rb_mode = 1;
    v0 = 4'b1000; we0 = 4'b0000;
    ad0[19:15] = 5'b11001; dt0[103:78] = 26'h0000123;
    #1;
    n_total++;
    if (rdy0 !== 4'b1000) $display("FAIL un_ready: got %b want 1000", rdy0);
    else n_pass++;
    tick();
    v0 = '0;
    n_total++;
    if (bus0 !== 32'h64000123) $display("FAIL un_bus: got %h want 64000123", bus0);
    else n_pass++;
    saw31 = bus0[31];
    n = 1;
    while (!rv0 && n < 20) begin
      tick();
      n++;
      saw31 = saw31 | bus0[31];
    end
    n_total++;
    if (saw31 !== 1'b0) $display("FAIL un_bit31: got %b want 0", saw31);
    else n_pass++;
    n_total++;
    if (rerr0 !== 1'b1) $display("FAIL un_err: got %b want 1", rerr0);
    else n_pass++;
    n_total++;
    if (rid0 !== 3'd3) $display("FAIL un_id: got %0d want 3", rid0);
    else n_pass++;
    tick();
    rb_mode = 0;
  endtask

  task automatic test_stale();
    int n;
    rb_mode = 2;
    v0 = 4'b0001; we0 = 4'b0001;
    ad0[4:0] = 5'b00001; dt0[25:0] = 26'h1;
    #1;
    n_total++;
    if (rdy0 !== 4'b0001) $display("FAIL st_ready: got %b want 0001", rdy0);
    else n_pass++;
    tick();
    v0 = '0;
    n_total++;
    if (bus0 !== 32'h84000001) $display("FAIL st_bus: got %h want 84000001", bus0);
    else n_pass++;
    n = 1;
    wait_rsp0(n);
    n_total++;
    if (rerr0 !== 1'b1) $display("FAIL st_err: got %b want 1", rerr0);
    else n_pass++;
    n_total++;
    if (rdat0 !== 26'h0) $display("FAIL st_data: got %h want 0", rdat0);
    else n_pass++;
    tick();
    rb_mode = 0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    logic saw_rv;
    v0 = 4'b0001; we0 = 4'b0001;
    ad0[4:0] = 5'b00010; dt0[25:0] = 26'h55;
    #1;
    n_total++;
    if (rdy0 !== 4'b0001) $display("FAIL mw_ready: got %b want 0001", rdy0);
    else n_pass++;
    tick();
    v0 = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if (bus0 !== 32'h0) $display("FAIL mw_bus: got %h want 0", bus0);
    else n_pass++;
    saw_rv = rv0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_rv = saw_rv | rv0;
    end
    n_total++;
    if (saw_rv !== 1'b0) $display("FAIL mw_no_rsp: got %b want 0", saw_rv);
    else n_pass++;
    v0 = 4'b0011; we0 = 4'b0000;
    #1;
    n_total++;
    if (rdy0 !== 4'b0001) $display("FAIL mw_regrant: got %b want 0001", rdy0);
    else n_pass++;
    tick();
    v0 = '0;
    n = 1;
    wait_rsp0(n);
    n_total++;
    if (rid0 !== 3'd0) $display("FAIL mw_id: got %0d want 0", rid0);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int w;
    int n;
    logic [3:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    v0 = 4'hF; we0 = 4'h0;
    ad0 = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    w = 0;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      while (rdy0 === 4'b0 && w < 12) begin
        tick();
        w++;
      end
      n_total++;
      if (rdy0 !== exp) $display("FAIL rr_grant%0d: got %b want %b", g, rdy0, exp);
      else n_pass++;
      if (g > 0) begin
        n_total++;
        if (w !== 5) $display("FAIL rr_gap%0d: got %0d want 5", g, w);
        else n_pass++;
      end
      tick();
      w = 1;
    end
    v0 = '0;
    n = 1;
    wait_rsp0(n);
    tick();
  endtask

  task automatic test_latency1();
    int n;
    v1 = 4'b0001; we1 = 4'b0001;
    ad1[4:0] = 5'b01011; dt1[25:0] = 26'h2A5A5A5;
    #1;
    n_total++;
    if (rdy1 !== 4'b0001) $display("FAIL l1_ready: got %b want 0001", rdy1);
    else n_pass++;
    tick();
    v1 = '0;
    n_total++;
    if (bus1 !== 32'hAEA5A5A5) $display("FAIL l1_issue_bus: got %h want aea5a5a5", bus1);
    else n_pass++;
    tick();
    n_total++;
    if (bus1 !== 32'h2EA5A5A5) $display("FAIL l1_wait_bus: got %h want 2ea5a5a5", bus1);
    else n_pass++;
    n = 2;
    while (!rv1 && n < 20) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 3) $display("FAIL l1_latency: got %0d want 3", n);
    else n_pass++;
    n_total++;
    if (rdat1 !== 26'h2A5A5A5) $display("FAIL l1_data: got %h want 2a5a5a5", rdat1);
    else n_pass++;
    n_total++;
    if (rerr1 !== 1'b0) $display("FAIL l1_err: got %b want 0", rerr1);
    else n_pass++;
    tick();
  endtask

  initial begin
    rb_mode = 0;
    test_reset();
    test_write();
    test_read_echo();
    test_read_unused();
    test_stale();
    test_reset_mid_wait();
    test_round_robin();
    test_latency1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
